// File: rtl/fp32_mul_pkg.sv
// rtl/fp32_mul_pkg.sv - shared types and constants for the FP32 multiplier arbiter
package fp32_mul_pkg;

    typedef logic [31:0] fp32_t;

    localparam int FP32_MUL_LATENCY = 3;

    // Width of a requester ID; never narrower than one bit so the types stay legal.
    function automatic int req_id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/fp32_tag_fifo.sv
// rtl/fp32_tag_fifo.sv - in-flight requester ID FIFO, simultaneous push/pop allowed
module fp32_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    // Occupancy is tracked by the owner's credit counter, so no full/empty flags here.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/fp32_mul_arbiter.sv
// rtl/fp32_mul_arbiter.sv - round-robin sharing of one pipelined FP32 multiplier
// with credit limiting and in-order result routing by requester tag.
module fp32_mul_arbiter
    import fp32_mul_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int MUL_LATENCY  = FP32_MUL_LATENCY,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ-1:0][31:0] req_a,
    input  logic [NUM_REQ-1:0][31:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     mul_tvalid,
    output logic [31:0]              mul_a_tdata,
    output logic [31:0]              mul_b_tdata,
    input  logic                     mul_result_tvalid,
    input  logic [31:0]              mul_result_tdata,
    output logic                     busy,
    output logic                     err_orphan
);

    localparam int IDW = req_id_width(NUM_REQ);
    localparam int CW  = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [IDW:0]         NREQ_W   = (IDW+1)'(NUM_REQ);
    localparam logic [CW-1:0]        MAX_W    = CW'(MAX_INFLIGHT);
    localparam logic [NUM_REQ-1:0]   ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef logic [IDW-1:0] req_id_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MUL_LATENCY < 1 || MAX_INFLIGHT < 2 ||
        (MAX_INFLIGHT & (MAX_INFLIGHT - 1)) != 0) begin : g_bad_cfg
        $error("fp32_mul_arbiter: unsupported parameter set");
    end

    req_id_t             ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mul_tvalid_q, mul_tvalid_d;
    fp32_t               mul_a_q, mul_a_d;
    fp32_t               mul_b_q, mul_b_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    fp32_t               rsp_data_q, rsp_data_d;
    logic                busy_q, busy_d;
    logic                err_orphan_q, err_orphan_d;

    logic [2*NUM_REQ-1:0] rot;
    logic                 found;
    req_id_t              off;
    logic [IDW:0]         sum;
    logic [IDW:0]         nxt;
    req_id_t              win_id;
    req_id_t              head_id;
    logic                 accept;
    logic                 pop;

    // Rotating the doubled request vector by ptr puts the highest-priority
    // requester at bit 0; the lowest set bit is the offset of the winner.
    always_comb begin
        rot   = {req_valid, req_valid} >> ptr_q;
        found = 1'b0;
        off   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                off   = req_id_t'(j);
            end
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        win_id    = sum[IDW-1:0];
        accept    = found && (cnt_q < MAX_W);
        req_ready = accept ? (ONE_HOT0 << win_id) : '0;
    end

    always_comb begin
        pop = mul_result_tvalid && (cnt_q != '0);
        nxt = {1'b0, win_id} + 1'b1;

        ptr_d        = ptr_q;
        mul_tvalid_d = accept;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        if (accept) begin
            ptr_d   = (nxt == NREQ_W) ? '0 : nxt[IDW-1:0];
            mul_a_d = req_a[win_id];
            mul_b_d = req_b[win_id];
        end

        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        busy_d = (cnt_d != '0);

        rsp_valid_d  = pop ? (ONE_HOT0 << head_id) : '0;
        rsp_data_d   = pop ? mul_result_tdata : rsp_data_q;
        // A result with nothing outstanding cannot be routed; flag it and drop it.
        err_orphan_d = err_orphan_q | (mul_result_tvalid && (cnt_q == '0));
    end

    fp32_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .W     (IDW)
    ) u_tag_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (accept),
        .push_data (win_id),
        .pop       (pop),
        .pop_data  (head_id)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q        <= '0;
            cnt_q        <= '0;
            mul_tvalid_q <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            mul_tvalid_q <= mul_tvalid_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            busy_q       <= busy_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign mul_tvalid  = mul_tvalid_q;
    assign mul_a_tdata = mul_a_q;
    assign mul_b_tdata = mul_b_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign busy        = busy_q;
    assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// tb/tb_fp32_mul_arbiter.sv - bench for fp32_mul_arbiter with a 3-cycle multiplier stand-in
module tb_fp32_mul_arbiter;

    localparam int N = 4;

    typedef struct {
        int          id;
        logic [31:0] d;
        int          c;
    } exp_t;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc++;

    int nvec = 0;
    int nerr = 0;
    int m_ptr = 0;

    logic [N-1:0]       v0 = '0, rdy0, rv0;
    logic [N-1:0][31:0] a0 = '0, b0 = '0;
    logic [31:0]        rd0, ma0, mb0, rtd0;
    logic               mv0, rtv0, busy0, orph0;
    logic               inj0 = 1'b0;

    logic [N-1:0]       v1 = '0, rdy1, rv1;
    logic [N-1:0][31:0] a1 = '0, b1 = '0;
    logic [31:0]        rd1, ma1, mb1, rtd1;
    logic               mv1, rtv1, busy1, orph1;

    // Truncating FP32 multiply for normal operands; stands in for the multiplier IP.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        logic [22:0] f;
        m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (m[47]) begin
            f = m[46:24];
            e = e + 10'd1;
        end else begin
            f = m[45:23];
        end
        return {a[31] ^ b[31], e[7:0], f};
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (v[idx[1:0]]) return idx;
        end
        return -1;
    endfunction

    fp32_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(3), .MAX_INFLIGHT(8)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(v0), .req_ready(rdy0), .req_a(a0), .req_b(b0),
        .rsp_valid(rv0), .rsp_data(rd0),
        .mul_tvalid(mv0), .mul_a_tdata(ma0), .mul_b_tdata(mb0),
        .mul_result_tvalid(rtv0), .mul_result_tdata(rtd0),
        .busy(busy0), .err_orphan(orph0)
    );

    fp32_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(3), .MAX_INFLIGHT(2)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(v1), .req_ready(rdy1), .req_a(a1), .req_b(b1),
        .rsp_valid(rv1), .rsp_data(rd1),
        .mul_tvalid(mv1), .mul_a_tdata(ma1), .mul_b_tdata(mb1),
        .mul_result_tvalid(rtv1), .mul_result_tdata(rtd1),
        .busy(busy1), .err_orphan(orph1)
    );

    logic [2:0]  pv0, pv1;
    logic [31:0] pd0 [3];
    logic [31:0] pd1 [3];

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pv0 <= '0;
            pv1 <= '0;
        end else begin
            pv0 <= {pv0[1:0], mv0};
            pv1 <= {pv1[1:0], mv1};
            pd0[0] <= fmul(ma0, mb0);
            pd0[1] <= pd0[0];
            pd0[2] <= pd0[1];
            pd1[0] <= fmul(ma1, mb1);
            pd1[1] <= pd1[0];
            pd1[2] <= pd1[1];
        end
    end

    assign rtv0 = pv0[2] | inj0;
    assign rtd0 = inj0 ? 32'hDEAD_BEEF : pd0[2];
    assign rtv1 = pv1[2];
    assign rtd1 = pd1[2];

    // In-order scoreboard for dut0: every accept must come back once, to its
    // requester, with the product, exactly 5 cycles later.
    exp_t sb_q[$];
    bit   sb_en = 1'b0;

    always @(negedge aclk) begin
        exp_t e;
        if (sb_en && aresetn) begin
            if (rv0 !== '0) begin
                nvec++;
                if (sb_q.size() == 0) begin
                    nerr++;
                    $display("FAIL sb_rsp unexpected rsp_valid=%b data=%h", rv0, rd0);
                end else begin
                    e = sb_q.pop_front();
                    if (rv0 !== (4'b1 << e.id) || rd0 !== e.d || cyc !== e.c + 5) begin
                        nerr++;
                        $display("FAIL sb_rsp got rsp_valid=%b data=%h cyc=%0d required rsp_valid=%b data=%h cyc=%0d",
                                 rv0, rd0, cyc, 4'b1 << e.id, e.d, e.c + 5);
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (v0[i] && rdy0[i]) sb_q.push_back('{i, fmul(a0[i], b0[i]), cyc});
            end
        end
    end

    task automatic drain0(input string name);
        repeat (8) @(posedge aclk);
        @(negedge aclk);
        nvec++;
        if (sb_q.size() != 0 || busy0 !== 1'b0) begin
            nerr++;
            $display("FAIL %s_drain outstanding=%0d busy=%b required 0 and 0", name, sb_q.size(), busy0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge aclk);
        nvec++;
        if ({rdy0, rv0, rd0, mv0, ma0, mb0, busy0, orph0} !== '0) begin
            nerr++;
            $display("FAIL reset_dut0 outputs=%h required 0", {rdy0, rv0, rd0, mv0, ma0, mb0, busy0, orph0});
        end
        nvec++;
        if ({rdy1, rv1, rd1, mv1, ma1, mb1, busy1, orph1} !== '0) begin
            nerr++;
            $display("FAIL reset_dut1 outputs=%h required 0", {rdy1, rv1, rd1, mv1, ma1, mb1, busy1, orph1});
        end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        m_ptr   = 0;
        sb_en   = 1'b1;
    endtask

    task automatic test_round_robin();
        @(posedge aclk); #1;
        for (int i = 0; i < N; i++) begin
            a0[i] = rnd_fp();
            b0[i] = rnd_fp();
        end
        v0 = 4'hF;
        for (int k = 0; k < 12; k++) begin
            @(negedge aclk);
            nvec++;
            if (rdy0 !== (4'b1 << (k % N))) begin
                nerr++;
                $display("FAIL rr_grant k=%0d req_ready=%b required %b", k, rdy0, 4'b1 << (k % N));
            end
            m_ptr = (k % N + 1) % N;
            @(posedge aclk); #1;
            a0[k % N] = rnd_fp();
            b0[k % N] = rnd_fp();
        end
        v0 = '0;
        drain0("rr");
    endtask

    task automatic test_single();
        @(posedge aclk); #1;
        a0[2] = 32'h3FC0_0000;
        b0[2] = 32'h4000_0000;
        v0    = 4'b0100;
        @(negedge aclk);
        nvec++;
        if (rdy0 !== 4'b0100) begin
            nerr++;
            $display("FAIL single_accept req_ready=%b required 0100", rdy0);
        end
        m_ptr = 3;
        @(posedge aclk); #1;
        v0 = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge aclk);
            nvec++;
            if (mv0 !== 1'(k == 1) || busy0 !== 1'(k <= 4)) begin
                nerr++;
                $display("FAIL single_ctl T+%0d mul_tvalid=%b busy=%b required %b %b", k, mv0, busy0, k == 1, k <= 4);
            end
            nvec++;
            if (rv0 !== ((k == 5) ? 4'b0100 : 4'b0000)) begin
                nerr++;
                $display("FAIL single_rsp_valid T+%0d rsp_valid=%b", k, rv0);
            end
            if (k == 1) begin
                nvec++;
                if (ma0 !== 32'h3FC0_0000 || mb0 !== 32'h4000_0000) begin
                    nerr++;
                    $display("FAIL single_operands a=%h b=%h required 3fc00000 40000000", ma0, mb0);
                end
            end
            if (k == 5) begin
                nvec++;
                if (rd0 !== 32'h4040_0000) begin
                    nerr++;
                    $display("FAIL single_data rsp_data=%h required 40400000", rd0);
                end
            end
        end
    endtask

    task automatic test_random_traffic();
        logic [N-1:0] acc;
        logic [N-1:0] exp_rdy;
        int w;
        acc = '0;
        for (int k = 0; k < 150; k++) begin
            @(posedge aclk); #1;
            v0 = v0 & ~acc;
            for (int i = 0; i < N; i++) begin
                if (!v0[i] && $urandom_range(0, 1) == 1) begin
                    a0[i] = rnd_fp();
                    b0[i] = rnd_fp();
                    v0[i] = 1'b1;
                end
            end
            @(negedge aclk);
            w       = rr_pick(v0, m_ptr);
            exp_rdy = (w < 0) ? 4'b0000 : (4'b1 << w);
            nvec++;
            if (rdy0 !== exp_rdy) begin
                nerr++;
                $display("FAIL random_grant k=%0d valid=%b req_ready=%b required %b", k, v0, rdy0, exp_rdy);
            end
            acc = exp_rdy;
            if (w >= 0) m_ptr = (w + 1) % N;
        end
        @(posedge aclk); #1;
        v0 = '0;
        drain0("random");
    endtask

    task automatic test_back_to_back();
        @(posedge aclk); #1;
        v0    = 4'b0001;
        a0[0] = rnd_fp();
        b0[0] = rnd_fp();
        for (int k = 0; k < 20; k++) begin
            @(negedge aclk);
            nvec++;
            if (rdy0 !== 4'b0001) begin
                nerr++;
                $display("FAIL b2b_ready k=%0d req_ready=%b required 0001", k, rdy0);
            end
            if (k >= 4) begin
                nvec++;
                if (dut0.cnt_q !== 4'd4) begin
                    nerr++;
                    $display("FAIL b2b_cnt k=%0d cnt=%0d required 4", k, dut0.cnt_q);
                end
            end
            m_ptr = 1;
            @(posedge aclk); #1;
            a0[0] = rnd_fp();
            b0[0] = rnd_fp();
        end
        v0 = '0;
        drain0("b2b");
    endtask

    task automatic test_credit_stall();
        int          acc_cyc[$];
        logic [31:0] q1[$];
        int          obs[$];
        int          m_cnt, pops, nacc, nrsp, win;
        logic        exp_r;
        m_cnt = 0;
        nacc  = 0;
        nrsp  = 0;
        @(posedge aclk); #1;
        v1    = 4'b0001;
        a1[0] = rnd_fp();
        b1[0] = rnd_fp();
        for (int k = 0; k < 40; k++) begin
            @(negedge aclk);
            if (rv1 !== '0) begin
                nrsp++;
                nvec++;
                if (q1.size() == 0 || rv1 !== 4'b0001 || rd1 !== q1[0]) begin
                    nerr++;
                    $display("FAIL credit_rsp k=%0d rsp_valid=%b data=%h pending=%0d", k, rv1, rd1, q1.size());
                end
                if (q1.size() > 0) void'(q1.pop_front());
            end
            exp_r = (k < 25) && (m_cnt < 2);
            nvec++;
            if (rdy1 !== {3'b000, exp_r} || dut1.cnt_q !== 2'(m_cnt)) begin
                nerr++;
                $display("FAIL credit_ready k=%0d req_ready=%b cnt=%0d required %b %0d", k, rdy1, dut1.cnt_q, exp_r, m_cnt);
            end
            obs.push_back(int'(rdy1[0]));
            pops = 0;
            if (acc_cyc.size() > 0 && acc_cyc[0] == k - 4) begin
                pops = 1;
                void'(acc_cyc.pop_front());
            end
            if (exp_r) begin
                acc_cyc.push_back(k);
                q1.push_back(fmul(a1[0], b1[0]));
                nacc++;
            end
            m_cnt = m_cnt + int'(exp_r) - pops;
            @(posedge aclk); #1;
            if (k == 24) v1 = '0;
            if (exp_r) begin
                a1[0] = rnd_fp();
                b1[0] = rnd_fp();
            end
        end
        for (int s = 0; s + 5 <= 25; s++) begin
            win = obs[s] + obs[s+1] + obs[s+2] + obs[s+3] + obs[s+4];
            nvec++;
            if (win > 2) begin
                nerr++;
                $display("FAIL credit_window start=%0d accepts=%0d required <=2", s, win);
            end
        end
        nvec++;
        if (nrsp != nacc || q1.size() != 0 || busy1 !== 1'b0) begin
            nerr++;
            $display("FAIL credit_count responses=%0d accepts=%0d pending=%0d busy=%b", nrsp, nacc, q1.size(), busy1);
        end
    endtask

    task automatic test_orphan();
        @(posedge aclk); #1;
        inj0 = 1'b1;
        @(negedge aclk);
        nvec++;
        if (orph0 !== 1'b0 || busy0 !== 1'b0) begin
            nerr++;
            $display("FAIL orphan_pre err_orphan=%b busy=%b required 0 0", orph0, busy0);
        end
        @(posedge aclk); #1;
        inj0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            nvec++;
            if (orph0 !== 1'b1 || rv0 !== 4'b0000) begin
                nerr++;
                $display("FAIL orphan_sticky k=%0d err_orphan=%b rsp_valid=%b required 1 0000", k, orph0, rv0);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp_d;
        int          nrsp;
        nrsp = 0;
        @(posedge aclk); #1;
        v0    = 4'b1000;
        a0[3] = rnd_fp();
        b0[3] = rnd_fp();
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            nvec++;
            if (rdy0 !== 4'b1000) begin
                nerr++;
                $display("FAIL rstmid_issue k=%0d req_ready=%b required 1000", k, rdy0);
            end
            @(posedge aclk); #1;
            a0[3] = rnd_fp();
            b0[3] = rnd_fp();
        end
        v0      = '0;
        sb_en   = 1'b0;
        aresetn = 1'b0;
        sb_q.delete();
        m_ptr = 0;
        @(negedge aclk);
        nvec++;
        if ({rdy0, rv0, rd0, mv0, ma0, mb0, busy0, orph0} !== '0) begin
            nerr++;
            $display("FAIL rstmid_outputs outputs=%h required 0", {rdy0, rv0, rd0, mv0, ma0, mb0, busy0, orph0});
        end
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        sb_en   = 1'b1;
        @(posedge aclk); #1;
        v0    = 4'b0010;
        a0[1] = rnd_fp();
        b0[1] = rnd_fp();
        exp_d = fmul(a0[1], b0[1]);
        @(negedge aclk);
        nvec++;
        if (rdy0 !== 4'b0010) begin
            nerr++;
            $display("FAIL rstmid_accept req_ready=%b required 0010", rdy0);
        end
        m_ptr = 2;
        @(posedge aclk); #1;
        v0 = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            if (rv0 !== '0) begin
                nrsp++;
                nvec++;
                if (rv0 !== 4'b0010 || rd0 !== exp_d) begin
                    nerr++;
                    $display("FAIL rstmid_rsp rsp_valid=%b data=%h required 0010 %h", rv0, rd0, exp_d);
                end
            end
        end
        nvec++;
        if (nrsp != 1 || orph0 !== 1'b0) begin
            nerr++;
            $display("FAIL rstmid_count responses=%0d err_orphan=%b required 1 0", nrsp, orph0);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_random_traffic();
        test_back_to_back();
        test_credit_stall();
        test_orphan();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
